data_distributor: RTL and testbench

// - 1-to-2 data distributor (demultiplexer) with registered outputs.
// - Steers one DATA_W-bit input word to one of two output lanes, selected by select_line and gated by enable.
// - Sits between a single producer and two consumer paths; the consumers sample out0/out1 on the same clock.
//

---
 rtl/data_distributor_pkg.sv | 9 +
 rtl/data_distributor_lane.sv | 36 +++
 rtl/data_distributor.sv | 44 ++++
 tb/tb_data_distributor.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/data_distributor_pkg.sv
// Shared definitions for the 1-to-2 data distributor.
// Holds the default word width and the matching word type.
package data_distributor_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef logic [DATA_W_DEFAULT-1:0] dist_word_t;

endpackage : data_distributor_pkg

// File: rtl/data_distributor_lane.sv
// One registered output lane.
// It captures din while lane_en is high and clears to zero otherwise.
module data_distributor_lane
  import data_distributor_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lane_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] dout_d;
  logic [DATA_W-1:0] dout_q;

  // A disabled lane loads zero, so din (even X/Z) never reaches the flop.
  always_comb begin
    dout_d = '0;
    if (lane_en) begin
      dout_d = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule : data_distributor_lane

// File: rtl/data_distributor.sv
// 1-to-2 demultiplexer with registered outputs.
// At most one lane carries data per cycle; the other lane is cleared.
module data_distributor
  import data_distributor_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              select_line,
  input  logic [DATA_W-1:0] input_data,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1
);

  logic lane0_en;
  logic lane1_en;

  // The two enables are mutually exclusive, which keeps the lanes exclusive.
  assign lane0_en = enable & ~select_line;
  assign lane1_en = enable &  select_line;

  data_distributor_lane #(
    .DATA_W (DATA_W)
  ) u_lane0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .lane_en (lane0_en),
    .din     (input_data),
    .dout    (out0)
  );

  data_distributor_lane #(
    .DATA_W (DATA_W)
  ) u_lane1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .lane_en (lane1_en),
    .din     (input_data),
    .dout    (out1)
  );

endmodule : data_distributor

// File: tb/tb_data_distributor.sv
// Self-checking bench for data_distributor.
// Fixed vectors, reset corner sequences, and random traffic against a lane model.
module tb_data_distributor;
  import data_distributor_pkg::*;

  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              select_line;
  logic [DATA_W-1:0] input_data;
  logic [DATA_W-1:0] out0;
  logic [DATA_W-1:0] out1;

  int check_count = 0;
  int error_count = 0;

  typedef struct {
    logic       en;
    logic       sel;
    dist_word_t data;
    dist_word_t exp0;
    dist_word_t exp1;
    string      name;
  } vec_t;

  typedef struct {
    dist_word_t e0;
    dist_word_t e1;
  } exp_t;

  exp_t exp_q[$];

  data_distributor #(
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .select_line (select_line),
    .input_data  (input_data),
    .out0        (out0),
    .out1        (out1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (actual running, required finished)");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: the word lands on the lane picked by sel when enabled, all else is zero.
  function automatic exp_t model(input logic en, input logic sel, input dist_word_t d);
    dist_word_t lanes [2];
    exp_t r;
    lanes[0] = '0;
    lanes[1] = '0;
    if (en) lanes[sel] = d;
    r.e0 = lanes[0];
    r.e1 = lanes[1];
    return r;
  endfunction

  task automatic applyStimulus(input logic en, input logic sel, input dist_word_t d);
    @(negedge clk);
    enable      = en;
    select_line = sel;
    input_data  = d;
  endtask

  task automatic checkOutput(input string name, input dist_word_t e0, input dist_word_t e1);
    check_count++;
    if (out0 !== e0 || out1 !== e1) begin
      error_count++;
      $display("[TB] FAIL %s: actual out0=%h out1=%h, required out0=%h out1=%h",
               name, out0, out1, e0, e1);
    end
  endtask

  task automatic checkExclusive(input string name);
    check_count++;
    if (out0 !== '0 && out1 !== '0) begin
      error_count++;
      $display("[TB] FAIL %s: both lanes active, actual out0=%h out1=%h, required one of them 00",
               name, out0, out1);
    end
  endtask

  vec_t vecs [$];
  exp_t e;

  initial begin
    rst_n       = 1'b1;
    enable      = 1'b1;
    select_line = 1'b0;
    input_data  = 8'hFF;

    // T1: reset clears outputs immediately and holds them across edges
    #2 rst_n = 1'b0;
    #1 checkOutput("t1_reset_async", 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 checkOutput("t1_reset_hold", 8'h00, 8'h00);
    end

    @(negedge clk);
    enable = 1'b0;
    rst_n  = 1'b1;

    vecs.push_back('{1'b1, 1'b0, 8'hFF, 8'hFF, 8'h00, "t2_lane0"});
    vecs.push_back('{1'b1, 1'b1, 8'hAA, 8'h00, 8'hAA, "t3_lane1"});
    vecs.push_back('{1'b0, 1'b1, 8'h55, 8'h00, 8'h00, "t4_disable"});
    vecs.push_back('{1'b1, 1'b1, 8'h3C, 8'h00, 8'h3C, "lane1_again"});
    vecs.push_back('{1'b1, 1'b1, 8'h00, 8'h00, 8'h00, "zero_data"});
    vecs.push_back('{1'b1, 1'b0, 8'h01, 8'h01, 8'h00, "lane0_lsb"});
    vecs.push_back('{1'b1, 1'b1, 8'h80, 8'h00, 8'h80, "lane1_msb"});
    vecs.push_back('{1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, "disable_sel0"});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].en, vecs[i].sel, vecs[i].data);
      @(posedge clk);
      #1 checkOutput(vecs[i].name, vecs[i].exp0, vecs[i].exp1);
    end

    // Disabled with unknown inputs: nothing may leak out
    applyStimulus(1'b0, 1'bx, 'x);
    @(posedge clk);
    #1 checkOutput("disable_x_inputs", 8'h00, 8'h00);

    // T5: alternating stream, then reset pulse between edges
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, i[0], (i[0] ? 8'h22 : 8'h11));
      @(posedge clk);
      #1 checkOutput("t5_stream", (i[0] ? 8'h00 : 8'h11), (i[0] ? 8'h22 : 8'h00));
    end
    #2 rst_n = 1'b0;
    #1 checkOutput("t5_reset_async", 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h44);
    @(posedge clk);
    #1 checkOutput("t5_reset_held", 8'h00, 8'h00);
    @(negedge clk);
    enable = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk);
    #1 checkOutput("t5_release_idle", 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h33);
    @(posedge clk);
    #1 checkOutput("t5_first_after_release", 8'h33, 8'h00);

    // T6: back-to-back random traffic, then random enable as well
    for (int i = 0; i < 48; i++) begin
      logic       en;
      logic       sel;
      dist_word_t d;
      en  = (i < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      sel = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      applyStimulus(en, sel, d);
      exp_q.push_back(model(en, sel, d));
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        error_count++;
        $display("[TB] FAIL t6_model_empty: actual empty queue, required one entry");
      end else begin
        e = exp_q.pop_front();
        checkOutput((i < 8) ? "t6_back_to_back" : "random_traffic", e.e0, e.e1);
      end
      checkExclusive("t6_exclusive");
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule : tb_data_distributor
